// File: rtl/main_decode_pipe.sv
// main_decode_pipe
//   Registered RV32 main-decode stage sitting between fetch and execute.
//   Decodes the opcode/funct fields of an instruction into a control word,
//   flags illegal encodings, and forwards the PC and register indices through
//   a one-entry valid/ready pipeline register. A free-running counter tracks
//   how many legal instructions have been handed to execute.
//
// Optional feature:
//   DECODE_MEXT_EN  when defined, opcode 0110011 with funct7=0000001 decodes
//                   as an M-extension R-type (alu_op_o=11, mul_o=1). When not
//                   defined, that encoding is illegal and mul_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o    upstream handshake for instr_i / pc_i
//   instr_i, pc_i              instruction word and its PC
//   flush_i                    squash held and same-cycle incoming instruction
//   out_valid_o / out_ready_i  downstream handshake for the decoded word
//   reg_write_o .. ret_o       control bits (zero whenever out_valid_o=0)
//   imm_src_o                  000 I, 001 S, 010 B, 011 J, 100 U
//   write_src_o                00 ALU, 01 mem, 10 PC+4, 11 imm
//   alu_op_o                   00 add, 01 sub/compare, 10 funct-decoded, 11 mul
//   mul_o, illegal_o           M-extension op / illegal encoding held
//   rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o, pc_o   forwarded fields
//   decoded_cnt_o              legal instructions handed to execute (wraps)
module main_decode_pipe #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             reg_write_o,
  output logic             alu_src_o,
  output logic             alu_a_pc_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             branch_o,
  output logic             jump_o,
  output logic             ret_o,
  output logic [2:0]       imm_src_o,
  output logic [1:0]       write_src_o,
  output logic [1:0]       alu_op_o,
  output logic             mul_o,
  output logic             illegal_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [2:0]       funct3_o,
  output logic             funct7b5_o,
  output logic [PC_W-1:0]  pc_o,
  output logic [CNT_W-1:0] decoded_cnt_o
);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic [1:0] write_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       ret;
    logic       alu_a_pc;
    logic       mul;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]       opcode;
  logic [6:0]       funct7;
  ctrl_t            dec;
  ctrl_t            ctrl_q;
  logic             valid_q;
  logic             accept;
  logic [4:0]       rd_q, rs1_q, rs2_q;
  logic [2:0]       funct3_q;
  logic             funct7b5_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;

  assign opcode = instr_i[6:0];
  assign funct7 = instr_i[31:25];

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Opcode decode. Every listed opcode ends in 2'b11, so a compressed-looking
  // word (instr_i[1:0] != 2'b11) falls through to the illegal default.
  // Illegal words carry an all-zero control word except the illegal flag.
  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_JAL: begin
        dec.reg_write = 1'b1;  dec.imm_src   = 3'b011;
        dec.write_src = 2'b10; dec.jump      = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;  dec.alu_src   = 1'b1;
        dec.write_src = 2'b10; dec.alu_op    = 2'b10; dec.ret = 1'b1;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;  dec.alu_src   = 1'b1; dec.alu_op = 2'b10;
      end
      OP_REG: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.reg_write = 1'b1; dec.alu_op = 2'b10;
`ifdef DECODE_MEXT_EN
        end else if (funct7 == 7'b0000001) begin
          dec.reg_write = 1'b1; dec.alu_op = 2'b11; dec.mul = 1'b1;
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        dec.imm_src = 3'b001; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm_src = 3'b010; dec.alu_op = 2'b01; dec.branch = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.imm_src = 3'b100; dec.write_src = 2'b11;
      end
      OP_LOAD: begin
        dec.reg_write = 1'b1;  dec.alu_src  = 1'b1;
        dec.write_src = 2'b01; dec.mem_read = 1'b1;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.imm_src = 3'b100;
        dec.alu_src   = 1'b1; dec.alu_a_pc = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Pipeline register. Flush wins over everything; the payload only loads on
  // an accept, so it stays frozen while the output is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
      if (accept && !flush_i) begin
        ctrl_q     <= dec;
        rd_q       <= instr_i[11:7];
        rs1_q      <= instr_i[19:15];
        rs2_q      <= instr_i[24:20];
        funct3_q   <= instr_i[14:12];
        funct7b5_q <= instr_i[30];
        pc_q       <= pc_i;
      end
    end
  end

  // Only legal instructions actually taken by execute are counted; a handoff
  // coinciding with a flush is squashed and therefore not counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (valid_q && out_ready_i && !ctrl_q.illegal && !flush_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Control bits are masked by valid so a stale word never looks live.
  assign out_valid_o   = valid_q;
  assign reg_write_o   = valid_q & ctrl_q.reg_write;
  assign alu_src_o     = valid_q & ctrl_q.alu_src;
  assign alu_a_pc_o    = valid_q & ctrl_q.alu_a_pc;
  assign mem_read_o    = valid_q & ctrl_q.mem_read;
  assign mem_write_o   = valid_q & ctrl_q.mem_write;
  assign branch_o      = valid_q & ctrl_q.branch;
  assign jump_o        = valid_q & ctrl_q.jump;
  assign ret_o         = valid_q & ctrl_q.ret;
  assign imm_src_o     = valid_q ? ctrl_q.imm_src   : 3'b000;
  assign write_src_o   = valid_q ? ctrl_q.write_src : 2'b00;
  assign alu_op_o      = valid_q ? ctrl_q.alu_op    : 2'b00;
  assign mul_o         = valid_q & ctrl_q.mul;
  assign illegal_o     = valid_q & ctrl_q.illegal;
  assign rd_o          = rd_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign funct3_o      = funct3_q;
  assign funct7b5_o    = funct7b5_q;
  assign pc_o          = pc_q;
  assign decoded_cnt_o = cnt_q;

endmodule

// File: tb/tb_main_decode_pipe.sv
// tb_main_decode_pipe
//   Scoreboard bench for main_decode_pipe. The stimulus process pushes the
//   hand-computed decode of every instruction it gets accepted; a monitor pops
//   and compares on every output handshake. Build with +define+DECODE_MEXT_EN
//   to exercise the M-extension decode.
module tb_main_decode_pipe;

  // Control word layout: {reg_write, imm_src[2:0], alu_src, write_src[1:0],
  // alu_op[1:0], mem_read, mem_write, branch, jump, ret, alu_a_pc, mul, illegal}
  localparam logic [16:0] C_ADDI   = 17'b1_000_1_00_10_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_STORE  = 17'b0_001_1_00_00_0_1_0_0_0_0_0_0;
  localparam logic [16:0] C_BRANCH = 17'b0_010_0_00_01_0_0_1_0_0_0_0_0;
  localparam logic [16:0] C_JAL    = 17'b1_011_0_10_00_0_0_0_1_0_0_0_0;
  localparam logic [16:0] C_LUI    = 17'b1_100_0_11_00_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_AUIPC  = 17'b1_100_1_00_00_0_0_0_0_0_1_0_0;
  localparam logic [16:0] C_OP     = 17'b1_000_0_00_10_0_0_0_0_0_0_0_0;
  localparam logic [16:0] C_LOAD   = 17'b1_000_1_01_00_1_0_0_0_0_0_0_0;
  localparam logic [16:0] C_JALR   = 17'b1_000_1_10_10_0_0_0_0_1_0_0_0;
  localparam logic [16:0] C_ILL    = 17'b0_000_0_00_00_0_0_0_0_0_0_0_1;
`ifdef DECODE_MEXT_EN
  localparam logic [16:0] C_MUL    = 17'b1_000_0_00_11_0_0_0_0_0_0_1_0;
  localparam int          CNT_AFTER_MUL = 11;
`else
  localparam logic [16:0] C_MUL    = C_ILL;
  localparam int          CNT_AFTER_MUL = 10;
`endif

  typedef struct {
    logic [16:0] ctrl;
    logic [18:0] fld;
    logic [31:0] pc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic        reg_write_o, alu_src_o, alu_a_pc_o, mem_read_o, mem_write_o;
  logic        branch_o, jump_o, ret_o, mul_o, illegal_o, funct7b5_o;
  logic [2:0]  imm_src_o, funct3_o;
  logic [1:0]  write_src_o, alu_op_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [31:0] pc_o, decoded_cnt_o;

  logic [16:0] obs_ctrl;
  logic [18:0] obs_fld;
  exp_t        sb[$];
  logic [31:0] mon_cnt = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  main_decode_pipe #(.PC_W(32), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .reg_write_o(reg_write_o), .alu_src_o(alu_src_o),
    .alu_a_pc_o(alu_a_pc_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .branch_o(branch_o), .jump_o(jump_o), .ret_o(ret_o), .imm_src_o(imm_src_o),
    .write_src_o(write_src_o), .alu_op_o(alu_op_o), .mul_o(mul_o), .illegal_o(illegal_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
    .funct7b5_o(funct7b5_o), .pc_o(pc_o), .decoded_cnt_o(decoded_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign obs_ctrl = {reg_write_o, imm_src_o, alu_src_o, write_src_o, alu_op_o, mem_read_o,
                     mem_write_o, branch_o, jump_o, ret_o, alu_a_pc_o, mul_o, illegal_o};
  assign obs_fld  = {rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o};

  function automatic logic [18:0] fl(input int rd, input int rs1, input int rs2,
                                     input int f3, input int b5);
    return {5'(rd), 5'(rs1), 5'(rs2), 3'(f3), 1'(b5)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Presents one instruction and holds it until accepted; the expected decode
  // is queued only when the instruction should reach execute.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [16:0] ctrl, input logic [18:0] fld,
                               input bit expect_out);
    exp_t e;
    int   n;
    bit   done;
    in_valid_i = 1'b1;
    instr_i    = instr;
    pc_i       = pc;
    done       = 1'b0;
    n          = 0;
    while (!done && n < 20) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        done = 1'b1;
        if (expect_out) begin
          e.ctrl = ctrl; e.fld = fld; e.pc = pc;
          sb.push_back(e);
        end
      end
      @(posedge clk_i);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'(pc), 64'hFFFF_FFFF);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    checkOutput(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares every handoff against the scoreboard head and keeps an
  // independent model of the legal-instruction counter.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got pc=%h, required no output", pc_o);
        end else begin
          e = sb.pop_front();
          checkOutput("ctrl", 64'(obs_ctrl), 64'(e.ctrl));
          checkOutput("fields", 64'(obs_fld), 64'(e.fld));
          checkOutput("pc", 64'(pc_o), 64'(e.pc));
          checkOutput("cnt_at_handoff", 64'(decoded_cnt_o), 64'(mon_cnt));
          if (!e.ctrl[0] && !flush_i) mon_cnt = mon_cnt + 1;
        end
      end else if (!out_valid_o) begin
        checkOutput("idle_ctrl_zero", 64'(obs_ctrl), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] cnt_snap;
    int          t0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_valid", 64'(out_valid_o), 64'd0);
    checkOutput("rst_cnt", 64'(decoded_cnt_o), 64'd0);
    checkOutput("rst_ctrl", 64'(obs_ctrl), 64'd0);
    checkOutput("rst_fields_pc", {13'd0, obs_fld, pc_o}, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready_o), 64'd1);

    // Back-to-back stream at full throughput
    t0 = cyc;
    applyStimulus(32'h0050_0093, 32'h100, C_ADDI,   fl(1, 0, 5, 0, 0),  1);
    applyStimulus(32'h0020_8223, 32'h104, C_STORE,  fl(4, 1, 2, 0, 0),  1);
    applyStimulus(32'h0020_9463, 32'h108, C_BRANCH, fl(8, 1, 2, 1, 0),  1);
    applyStimulus(32'h0100_00EF, 32'h10C, C_JAL,    fl(1, 0, 16, 0, 0), 1);
    applyStimulus(32'h1234_52B7, 32'h110, C_LUI,    fl(5, 8, 3, 5, 0),  1);
    applyStimulus(32'h0000_1317, 32'h114, C_AUIPC,  fl(6, 0, 0, 1, 0),  1);
    checkOutput("stream_cycles", 64'(cyc - t0), 64'd6);
    waitDrain("stream_drain");
    checkOutput("stream_cnt", 64'(decoded_cnt_o), 64'd6);

    // Backpressure: two pending, sink stalled three cycles
    out_ready_i = 1'b0;
    applyStimulus(32'h0020_81B3, 32'h200, C_OP, fl(3, 1, 2, 0, 0), 1);
    fork
      applyStimulus(32'h0000_A203, 32'h204, C_LOAD, fl(4, 1, 0, 2, 0), 1);
      begin
        repeat (3) begin
          @(negedge clk_i);
          checkOutput("bp_valid", 64'(out_valid_o), 64'd1);
          checkOutput("bp_in_ready", 64'(in_ready_o), 64'd0);
          checkOutput("bp_stable_pc", 64'(pc_o), 64'h200);
          checkOutput("bp_stable_ctrl", 64'(obs_ctrl), 64'(C_OP));
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
      end
    join
    waitDrain("bp_drain");
    checkOutput("bp_cnt", 64'(decoded_cnt_o), 64'd8);

    // sub (funct7b5=1) and jalr
    applyStimulus(32'h4020_82B3, 32'h300, C_OP,   fl(5, 1, 2, 0, 1), 1);
    applyStimulus(32'h0000_8067, 32'h304, C_JALR, fl(0, 1, 0, 0, 0), 1);
    waitDrain("misc_drain");
    checkOutput("misc_cnt", 64'(decoded_cnt_o), 64'd10);

    // Illegal encodings: unknown opcode and non-11 low bits
    applyStimulus(32'hFFFF_FFFF, 32'h400, C_ILL, fl(31, 31, 31, 7, 1), 1);
    applyStimulus(32'h0050_0090, 32'h404, C_ILL, fl(1, 0, 5, 0, 0),    1);
    waitDrain("ill_drain");
    checkOutput("ill_cnt", 64'(decoded_cnt_o), 64'd10);

    // M-extension multiply
    applyStimulus(32'h0220_81B3, 32'h500, C_MUL, fl(3, 1, 2, 0, 0), 1);
    waitDrain("mul_drain");
    checkOutput("mul_cnt", 64'(decoded_cnt_o), 64'(CNT_AFTER_MUL));

    // Flush with a stalled held word and a blocked new input
    out_ready_i = 1'b0;
    applyStimulus(32'h0050_0093, 32'h600, C_ADDI, fl(1, 0, 5, 0, 0), 0);
    in_valid_i = 1'b1;
    instr_i    = 32'h0000_A203;
    pc_i       = 32'h604;
    flush_i    = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("flush1_valid", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("flush1_still_idle", 64'(out_valid_o), 64'd0);

    // Flush coinciding with a handoff and an accepted input
    cnt_snap = decoded_cnt_o;
    applyStimulus(32'h0050_0093, 32'h700, C_ADDI, fl(1, 0, 5, 0, 0), 1);
    in_valid_i = 1'b1;
    instr_i    = 32'h1234_52B7;
    pc_i       = 32'h704;
    flush_i    = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("flush2_valid", 64'(out_valid_o), 64'd0);
    checkOutput("flush2_cnt", 64'(decoded_cnt_o), 64'(CNT_AFTER_MUL));
    checkOutput("flush2_cnt_model", 64'(decoded_cnt_o), 64'(cnt_snap));
    waitDrain("flush2_drain");

    // Asynchronous reset with an instruction held
    out_ready_i = 1'b0;
    applyStimulus(32'h0050_0093, 32'h800, C_ADDI, fl(1, 0, 5, 0, 0), 0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid_o), 64'd0);
    checkOutput("arst_cnt", 64'(decoded_cnt_o), 64'd0);
    checkOutput("arst_ctrl", 64'(obs_ctrl), 64'd0);
    sb.delete();
    mon_cnt = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("arst_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("arst_valid_after", 64'(out_valid_o), 64'd0);

    // Pipe works again after reset
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus(32'h0000_1317, 32'h900, C_AUIPC, fl(6, 0, 0, 1, 0), 1);
    waitDrain("post_rst_drain");
    checkOutput("post_rst_cnt", 64'(decoded_cnt_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
